// File: rtl/reg_reader.sv
// Sweeps a range of register-bank indices, emitting one captured word per valid/ready handshake and keeping running complex sums.
// Latency: 3 cycles per word (READ, CAPT, SEND) with ready held high; done pulses one cycle after the final handshake or an abort.
module reg_reader #(
    parameter int DW = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [3:0]      first,
    input  logic [3:0]      last,
    output logic [3:0]      seloutA,
    output logic            enrregA,
    input  logic [DW-1:0]   outA,
    output logic [DW-1:0]   dout,
    output logic [3:0]      dout_idx,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            busy,
    output logic            done,
    output logic [DW/2-1:0] sum_re,
    output logic [DW/2-1:0] sum_im
);

    typedef enum logic [2:0] {IDLE, READ, CAPT, SEND, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] idx;
    logic [3:0] last_q;
    logic [3:0] sel_q;
    logic       hs;

    assign hs = (state == SEND) && dout_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    state_nxt = abort ? DONE : CAPT;
            CAPT:    state_nxt = abort ? DONE : SEND;
            // A handshake coinciding with abort still counts; abort just skips the next read.
            SEND: begin
                if (hs && idx == last_q) state_nxt = DONE;
                else if (abort)          state_nxt = DONE;
                else if (hs)             state_nxt = READ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        enrregA    = (state == READ);
        seloutA    = (state == READ) ? idx : sel_q;
        dout_valid = (state == SEND);
        busy       = (state != IDLE);
        done       = (state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            last_q   <= '0;
            sel_q    <= '0;
            dout     <= '0;
            dout_idx <= '0;
            sum_re   <= '0;
            sum_im   <= '0;
        end else begin
            if (state == IDLE && start) begin
                idx    <= first;
                last_q <= last;
                sum_re <= '0;
                sum_im <= '0;
            end
            if (state == READ) begin
                sel_q <= idx;
            end
            // The bank answers one cycle after the enable, so outA is valid during CAPT.
            if (state == CAPT) begin
                dout     <= outA;
                dout_idx <= idx;
            end
            if (hs) begin
                sum_re <= sum_re + dout[DW-1:DW/2];
                sum_im <= sum_im + dout[DW/2-1:0];
                idx    <= idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_reader.sv
// Directed bench for reg_reader: table of sweeps plus hand sequences for stall, abort and reset.
module tb_reg_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [3:0]  first;
    logic [3:0]  last;
    logic [3:0]  seloutA;
    logic        enrregA;
    logic [63:0] outA;
    logic [63:0] dout;
    logic [3:0]  dout_idx;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        done;
    logic [31:0] sum_re;
    logic [31:0] sum_im;

    int checks   = 0;
    int failures = 0;
    int pat      = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;

    reg_reader #(.DW(64)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .first(first), .last(last), .seloutA(seloutA), .enrregA(enrregA),
        .outA(outA), .dout(dout), .dout_idx(dout_idx), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .busy(busy), .done(done),
        .sum_re(sum_re), .sum_im(sum_im)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] bank_word(input int p, input logic [3:0] k);
        logic [31:0] kk;
        kk = {28'd0, k};
        case (p)
            0:       return {32'd20, 32'd20};
            1:       return {kk, 32'd0 - kk};
            default: return {32'h7FFF_FFFF, 32'h8000_0000};
        endcase
    endfunction

    // Register bank model: data appears one cycle after the read enable.
    always @(posedge clock) begin
        if (enrregA) outA <= bank_word(pat, seloutA);
    end

    always @(negedge clock) begin
        if (dout_valid && dout_ready) hs_cnt++;
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " seloutA"}, 64'(seloutA), 0);
        chk({tag, " enrregA"}, 64'(enrregA), 0);
        chk({tag, " dout"}, dout, 0);
        chk({tag, " dout_idx"}, 64'(dout_idx), 0);
        chk({tag, " dout_valid"}, 64'(dout_valid), 0);
        chk({tag, " busy"}, 64'(busy), 0);
        chk({tag, " done"}, 64'(done), 0);
        chk({tag, " sum_re"}, 64'(sum_re), 0);
        chk({tag, " sum_im"}, 64'(sum_im), 0);
    endtask

    // Full sweep with ready held high; checks order, data, timing and sums.
    task automatic run_sweep(input logic [3:0] f, input logic [3:0] l, input int p,
                             input int en, input logic [31:0] ere, input logic [31:0] eim,
                             input string nm);
        int         cyc;
        int         n;
        logic [3:0] ei;
        logic       seen_done;
        cyc = 0; n = 0; ei = f; seen_done = 1'b0;
        pat = p; first = f; last = l; dout_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({nm, " sum_re cleared"}, 64'(sum_re), 0);
        chk({nm, " first seloutA"}, 64'(seloutA), 64'(f));
        while (!seen_done && cyc < 200) begin
            if (dout_valid) begin
                chk({nm, " idx"}, 64'(dout_idx), 64'(ei));
                chk({nm, " data"}, dout, bank_word(p, ei));
                n++;
                ei = ei + 4'd1;
            end
            if (done) seen_done = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        chk({nm, " done seen"}, 64'(seen_done), 1);
        chk({nm, " words"}, 64'(n), 64'(en));
        chk({nm, " cycles"}, 64'(cyc), 64'(3 * en));
        chk({nm, " sum_re"}, 64'(sum_re), 64'(ere));
        chk({nm, " sum_im"}, 64'(sum_im), 64'(eim));
        step();
        chk({nm, " idle busy"}, 64'(busy), 0);
        chk({nm, " done width"}, 64'(done), 0);
        chk({nm, " sums held"}, 64'(sum_re), 64'(ere));
    endtask

    typedef struct {
        logic [3:0]  f;
        logic [3:0]  l;
        int          p;
        int          n;
        logic [31:0] re;
        logic [31:0] im;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int hs0;
        int dc0;
        vecs[0] = '{f: 4'd0,  l: 4'd15, p: 0, n: 16, re: 32'h140,       im: 32'h140};
        vecs[1] = '{f: 4'd14, l: 4'd1,  p: 1, n: 4,  re: 32'd30,        im: 32'hFFFF_FFE2};
        vecs[2] = '{f: 4'd7,  l: 4'd7,  p: 1, n: 1,  re: 32'd7,         im: 32'hFFFF_FFF9};
        vecs[3] = '{f: 4'd0,  l: 4'd15, p: 1, n: 16, re: 32'd120,       im: 32'hFFFF_FF88};
        vecs[4] = '{f: 4'd15, l: 4'd0,  p: 1, n: 2,  re: 32'd15,        im: 32'hFFFF_FFF1};
        vecs[5] = '{f: 4'd0,  l: 4'd1,  p: 2, n: 2,  re: 32'hFFFF_FFFE, im: 32'h0};

        reset = 1'b1; start = 1'b0; abort = 1'b0; first = '0; last = '0;
        dout_ready = 1'b1; outA = '0;
        step(); step();
        chk_reset_vals("reset");
        reset = 1'b0;
        step();

        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort idle busy", 64'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_sweep(vecs[i].f, vecs[i].l, vecs[i].p, vecs[i].n, vecs[i].re, vecs[i].im,
                      $sformatf("vec%0d", i));
        end

        // Stall in SEND for five cycles.
        pat = 1; first = 4'd2; last = 4'd3; dout_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        for (int c = 0; c < 5; c++) begin
            chk("stall valid", 64'(dout_valid), 1);
            chk("stall idx", 64'(dout_idx), 2);
            chk("stall data", dout, bank_word(1, 4'd2));
            chk("stall sum", 64'(sum_re), 0);
            chk("stall sel", 64'(seloutA), 2);
            step();
        end
        dout_ready = 1'b1;
        step();
        chk("stall sum_re after", 64'(sum_re), 2);
        chk("stall sum_im after", 64'(sum_im), 64'(32'hFFFF_FFFE));
        for (int b = 0; b < 20 && !done; b++) step();
        chk("stall done", 64'(done), 1);
        chk("stall final sum", 64'(sum_re), 5);
        step();

        // Abort coinciding with a handshake: that word still counts.
        hs0 = hs_cnt;
        first = 4'd5; last = 4'd10; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort-hs done", 64'(done), 1);
        chk("abort-hs count", 64'(hs_cnt - hs0), 1);
        chk("abort-hs sum", 64'(sum_re), 5);
        step();

        // Abort in CAPT of word 3, with a stray start mid-sweep.
        pat = 0; hs0 = hs_cnt;
        first = 4'd0; last = 4'd15; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 5; c++) step();
        start = 1'b1; first = 4'd9;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) step();
        chk("capt enr", 64'(enrregA), 0);
        chk("capt valid", 64'(dout_valid), 0);
        chk("capt sel", 64'(seloutA), 3);
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        chk("abort done", 64'(done), 1);
        chk("abort count", 64'(hs_cnt - hs0), 3);
        chk("abort sum", 64'(sum_re), 60);
        step();
        chk("abort busy", 64'(busy), 0);
        chk("abort done width", 64'(done), 0);

        // Reset in SEND of word 5.
        first = 4'd0; last = 4'd15; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 17; c++) step();
        chk("pre-reset valid", 64'(dout_valid), 1);
        chk("pre-reset idx", 64'(dout_idx), 5);
        dc0 = done_cnt;
        reset = 1'b1;
        #1;
        chk_reset_vals("midreset");
        step(); step();
        reset = 1'b0;
        step();
        chk("no done after reset", 64'(done_cnt - dc0), 0);
        run_sweep(4'd0, 4'd0, 0, 1, 32'd20, 32'd20, "post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_reader.md
REG_READER -- requirements
Module: reg_reader

Interface
REQ-001 Parameter DW, default 64: register word width; upper DW/2 bits real part, lower DW/2 bits imaginary part (both signed).
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminates a sweep in progress.
REQ-006 first  input  4  first register index of the sweep; sampled with start.
REQ-007 last  input  4  last register index of the sweep; sampled with start.
REQ-008 seloutA  output  4  read address driven to the register bank read port A.
REQ-009 enrregA  output  1  read-register enable to the bank; bank presents outA one cycle after enrregA=1.
REQ-010 outA  input  DW  read data from the register bank port A.
REQ-011 dout  output  DW  captured register word.
REQ-012 dout_idx  output  4  register index of dout.
REQ-013 dout_valid  output  1  dout/dout_idx valid.
REQ-014 dout_ready  input  1  downstream accepts dout when high with dout_valid.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at end of a completed or aborted sweep.
REQ-017 sum_re, sum_im  output  DW/2 each  running sums of real/imag parts of all handshaken words.

Function
REQ-018 FSM states SHALL be IDLE, READ, CAPT, SEND, DONE.
REQ-019 IDLE: start=1 latches first/last, sets idx=first, clears sum_re/sum_im, goes to READ.
REQ-020 start while not IDLE SHALL be ignored.
REQ-021 READ (one cycle): seloutA=idx, enrregA=1; next CAPT.
REQ-022 CAPT (one cycle): dout<=outA, dout_idx<=idx; next SEND; enrregA=0.
REQ-023 SEND: dout_valid=1; dout, dout_idx stable until handshake (dout_valid&dout_ready).
REQ-024 On handshake: sum_re+=dout[DW-1:DW/2], sum_im+=dout[DW/2-1:0], modulo 2^(DW/2) wrap, no saturation.
REQ-025 On handshake with idx==last: next DONE; else idx<=idx+1 mod 16, next READ.
REQ-026 Sweep order wraps 15->0; last<first is legal (e.g. 14,15,0,1); first==last yields exactly one word; maximum 16 words.
REQ-027 DONE (one cycle): done=1; next IDLE; sums hold until next accepted start.
REQ-028 abort=1 in READ, CAPT or SEND: next state DONE, no further handshake counted; abort and handshake in the same SEND cycle: the handshake IS counted, then DONE.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 Minimum throughput 3 cycles per word with dout_ready held high; dout_valid deasserts for READ and CAPT cycles between words.
REQ-031 seloutA SHALL hold its last driven value outside READ.

Reset
REQ-032 reset=1 SHALL asynchronously force: state IDLE, seloutA=0, enrregA=0, dout=0, dout_idx=0, dout_valid=0, busy=0, done=0, sum_re=0, sum_im=0.
REQ-033 reset mid-sweep SHALL discard the sweep without a done pulse; first start after reset release starts a fresh sweep.

Verification
REQ-034 Bank 0..15 all loaded with real=20, imag=20; start first=0 last=15, dout_ready=1 -> 16 words 0x0000001400000014, idx 0..15 in order, done after 48+ cycles, sum_re=sum_im=0x140.
REQ-035 Bank reg k holds {k, -k}; first=14 last=1 -> dout_idx sequence 14,15,0,1; sum_re=30, sum_im=0xFFFFFFE2.
REQ-036 first=last=7 -> exactly one dout_valid handshake, dout_idx=7, done one cycle later.
REQ-037 dout_ready low 5 cycles during SEND -> dout, dout_idx, dout_valid stable, no sum change, no seloutA change until ready rises.
REQ-038 abort asserted in CAPT of word 3 of sweep 0..15 -> 3 handshakes total, done pulse next cycle, busy then 0; start during sweep ignored.
REQ-039 reset pulsed in SEND of word 5 -> all outputs to REQ-032 values immediately, no done; subsequent start first=0 last=0 returns reg 0.
